// File: rtl/audio_pkg.sv
// Shared types and constants for the PDM playback path.
package audio_pkg;

    localparam int PCM_W       = 16;
    localparam int OSR_DEFAULT = 125;
    localparam int FS_PCM      = 32768;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Symmetric clamp to +/-(2^(w-1)-1) so the negated limit stays representable.
    function automatic logic signed [63:0] sat_clamp(input logic signed [63:0] v, input int w);
        logic signed [63:0] lim;
        lim = (64'sd1 <<< (w - 1)) - 64'sd1;
        if (v > lim)
            return lim;
        if (v < -lim)
            return -lim;
        return v;
    endfunction

endpackage

// File: rtl/audio_sdm2.sv
// Second-order sigma-delta modulator with saturating integrators.
module audio_sdm2
    import audio_pkg::*;
#(
    parameter int OSR = OSR_DEFAULT,
    parameter int W   = 28
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                stb,
    input  logic                clr,
    input  logic signed [W-1:0] x,
    output logic                pdm
);

    localparam logic signed [W-1:0] FS = W'(FS_PCM * OSR);

    logic signed [W-1:0] i1_reg;
    logic signed [W-1:0] i2_reg;
    logic signed [W-1:0] fb;
    logic signed [W-1:0] i1_next;
    logic signed [W-1:0] i2_next;
    logic                pdm_reg;

    // The second integrator takes the freshly updated first integrator, which
    // places both NTF poles at the origin: NTF = (1 - z^-1)^2.
    always_comb begin
        fb      = pdm_reg ? FS : -FS;
        i1_next = W'(sat_clamp(64'(i1_reg) + 64'(x) - 64'(fb), W));
        i2_next = W'(sat_clamp(64'(i2_reg) + 64'(i1_next) - 64'(fb), W));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i1_reg  <= '0;
            i2_reg  <= '0;
            pdm_reg <= 1'b0;
        end else if (stb) begin
            if (clr) begin
                // Cleared loop emits an alternating pattern: zero-mean silence.
                i1_reg  <= '0;
                i2_reg  <= '0;
                pdm_reg <= ~pdm_reg;
            end else begin
                i1_reg  <= i1_next;
                i2_reg  <= i2_next;
                pdm_reg <= ~i2_next[W-1];
            end
        end
    end

    assign pdm = pdm_reg;

endmodule

// File: rtl/audio_pdm_tx.sv
// PDM transmitter: one-entry PCM buffer, linear interpolator and run/idle
// control in front of the second-order modulator.
module audio_pdm_tx
    import audio_pkg::*;
#(
    parameter int OSR = OSR_DEFAULT,
    parameter int W   = 28
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    stb_sample,
    input  logic                    stb_pcm,
    input  logic                    enable,
    input  logic signed [PCM_W-1:0] pcm_in,
    input  logic                    pcm_valid,
    output logic                    pcm_ready,
    output logic                    pdm_out,
    output logic                    underrun
);

    localparam int KW = $clog2(OSR);

    state_t                  state_reg;
    logic signed [PCM_W-1:0] buf_reg;
    logic                    buf_full_reg;
    logic signed [PCM_W-1:0] cur_reg;
    logic signed [PCM_W-1:0] tgt_reg;
    logic [KW-1:0]           k_reg;
    logic                    underrun_reg;

    logic                    xfer;
    logic                    sdm_clr;
    logic signed [PCM_W:0]   delta;
    logic signed [W-1:0]     cur_ext;
    logic signed [W-1:0]     delta_ext;
    logic signed [W-1:0]     k_ext;
    logic signed [W-1:0]     interp;
    logic signed [W-1:0]     mod_x;

    assign xfer      = pcm_valid && !buf_full_reg;
    assign pcm_ready = !buf_full_reg;
    assign underrun  = underrun_reg;
    assign delta     = (PCM_W + 1)'(tgt_reg) - (PCM_W + 1)'(cur_reg);

    // Interpolated sample scaled by OSR; stepping k by one adds delta/OSR
    // of a PCM step, so no divider is needed.
    always_comb begin
        cur_ext   = W'(cur_reg);
        delta_ext = W'(delta);
        k_ext     = W'(k_reg);
        interp    = cur_ext * W'(OSR) + k_ext * delta_ext;
        mod_x     = interp >>> 1;
    end

    // The disabling stb_pcm already runs the modulator in cleared mode.
    assign sdm_clr = (state_reg == IDLE) || (stb_pcm && !enable);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            buf_reg      <= '0;
            buf_full_reg <= 1'b0;
            cur_reg      <= '0;
            tgt_reg      <= '0;
            k_reg        <= '0;
            underrun_reg <= 1'b0;
        end else begin
            underrun_reg <= 1'b0;
            if (xfer) begin
                buf_reg      <= pcm_in;
                buf_full_reg <= 1'b1;
            end
            if (state_reg == RUN && stb_sample && !stb_pcm && k_reg != KW'(OSR - 1))
                k_reg <= k_reg + KW'(1);
            // xfer needs an empty buffer and every consume below needs a full one.
            if (stb_pcm) begin
                case (state_reg)
                    IDLE: begin
                        if (enable && buf_full_reg) begin
                            state_reg    <= RUN;
                            tgt_reg      <= buf_reg;
                            cur_reg      <= '0;
                            k_reg        <= '0;
                            buf_full_reg <= 1'b0;
                        end
                    end
                    RUN: begin
                        if (!enable) begin
                            state_reg <= IDLE;
                            cur_reg   <= '0;
                            tgt_reg   <= '0;
                            k_reg     <= '0;
                        end else if (buf_full_reg) begin
                            cur_reg      <= tgt_reg;
                            tgt_reg      <= buf_reg;
                            buf_full_reg <= 1'b0;
                            k_reg        <= '0;
                        end else begin
                            cur_reg      <= tgt_reg;
                            k_reg        <= '0;
                            underrun_reg <= 1'b1;
                        end
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

    audio_sdm2 #(
        .OSR (OSR),
        .W   (W)
    ) u_sdm (
        .clk   (clk),
        .rst_n (rst_n),
        .stb   (stb_sample),
        .clr   (sdm_clr),
        .x     (mod_x),
        .pdm   (pdm_out)
    );

endmodule

// File: tb/tb_audio_pdm_tx.sv
// Directed bench for audio_pdm_tx: idle silence, ramp, tone densities,
// underrun handling, disable and asynchronous reset.
module tb_audio_pdm_tx;

    localparam int OSR = 125;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               stb_sample = 1'b0;
    logic               stb_pcm = 1'b0;
    logic               enable;
    logic signed [15:0] pcm_in;
    logic               pcm_valid;
    logic               pcm_ready;
    logic               pdm_out;
    logic               underrun;

    int n_checks = 0;
    int n_errors = 0;

    logic [1:0] div_reg = 2'd0;
    int         bit_reg = 0;
    int         acc_ones = 0;
    int         period_ones = 0;
    int         uc = 0;

    audio_pdm_tx #(.OSR(OSR), .W(28)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stb_sample (stb_sample),
        .stb_pcm    (stb_pcm),
        .enable     (enable),
        .pcm_in     (pcm_in),
        .pcm_valid  (pcm_valid),
        .pcm_ready  (pcm_ready),
        .pdm_out    (pdm_out),
        .underrun   (underrun)
    );

    always #5 clk = ~clk;

    // Strobe source: one PDM bit every 4 clks, one PCM period every OSR bits.
    always @(posedge clk) begin
        div_reg    <= div_reg + 2'd1;
        stb_sample <= (div_reg == 2'd2);
        stb_pcm    <= (div_reg == 2'd2) && (bit_reg == OSR - 1);
        if (div_reg == 2'd2)
            bit_reg <= (bit_reg == OSR - 1) ? 0 : bit_reg + 1;
    end

    // Ones per PCM period and count of clocks with underrun high.
    always @(posedge clk) begin
        if (stb_sample) begin
            if (stb_pcm) begin
                period_ones <= acc_ones + int'(pdm_out);
                acc_ones    <= 0;
            end else begin
                acc_ones <= acc_ones + int'(pdm_out);
            end
        end
        if (underrun)
            uc <= uc + 1;
    end

    task automatic check(input string tag, input longint got, input longint lo, input longint hi);
        n_checks++;
        if (got < lo || got > hi) begin
            n_errors++;
            $display("FAIL %s: got %0d, want %0d..%0d", tag, got, lo, hi);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    // Returns at the posedge on which the DUT samples stb_sample=1.
    task automatic wait_bit_edge();
        int t = 0;
        do begin
            @(posedge clk);
            t++;
        end while (!stb_sample && t < 64);
        if (!stb_sample)
            check("bit_timeout", 0, 1, 1);
    endtask

    // Returns 1 time unit after the posedge on which the DUT samples stb_pcm=1.
    task automatic wait_pcm();
        int t = 0;
        do begin
            @(posedge clk);
            t++;
        end while (!stb_pcm && t < 2000);
        if (!stb_pcm)
            check("pcm_timeout", 0, 1, 1);
        #1;
    endtask

    task automatic sum_periods(input int n, output int total);
        total = 0;
        for (int i = 0; i < n; i++) begin
            wait_pcm();
            total += period_ones;
        end
    endtask

    task automatic check_toggle(input string tag, input int n);
        logic first;
        wait_bit_edge();
        first = pdm_out;
        for (int i = 1; i < n; i++) begin
            wait_bit_edge();
            check(tag, int'(pdm_out), int'(first ^ logic'(i & 1)), int'(first ^ logic'(i & 1)));
        end
    endtask

    initial begin
        longint xs [OSR];
        int     total;
        int     viol;
        int     uc0;

        rst_n     = 1'b0;
        enable    = 1'b0;
        pcm_valid = 1'b0;
        pcm_in    = '0;
        #2;
        check("rst_pdm", int'(pdm_out), 0, 0);
        check("rst_underrun", int'(underrun), 0, 0);
        check("rst_ready", int'(pcm_ready), 1, 1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Idle silence and single-entry buffer.
        check_toggle("idle_toggle", 20);
        @(negedge clk);
        check("idle_ready", int'(pcm_ready), 1, 1);
        pcm_valid = 1'b1;
        pcm_in    = 16'sd16384;
        @(negedge clk);
        pcm_valid = 1'b0;
        check("ready_after_push", int'(pcm_ready), 0, 0);

        // Start: first period ramps 0 -> 16384 in steps of 8192 per bit.
        @(negedge clk);
        enable    = 1'b1;
        pcm_valid = 1'b1;
        wait_pcm();
        for (int i = 0; i < OSR; i++) begin
            wait_bit_edge();
            xs[i] = longint'(dut.mod_x);
        end
        viol = 0;
        for (int i = 1; i < OSR; i++)
            if (xs[i] < xs[i-1])
                viol++;
        check("ramp_first_x", xs[0], 0, 0);
        check("ramp_last_x", xs[OSR-1], 1015808, 1015808);
        check("ramp_monotonic_viol", viol, 0, 0);

        // +16384 tone: density 0.625.
        wait_pcm();
        wait_pcm();
        sum_periods(8, total);
        check("tone_pos_ones8", total, 617, 633);

        // Underrun: skip one sample; value held, single one-clk pulse.
        pcm_valid = 1'b0;
        uc0 = uc;
        wait_pcm();
        check("underrun_pulse", int'(underrun), 1, 1);
        @(posedge clk);
        #1;
        check("underrun_width", int'(underrun), 0, 0);
        pcm_valid = 1'b1;
        wait_pcm();
        check("underrun_hold_ones", period_ones, 76, 80);
        check("underrun_count", uc - uc0, 1, 1);

        // Handshake coincident with stb_pcm on an empty buffer.
        pcm_valid = 1'b0;
        for (int t = 0; t < 2000; t++) begin
            @(posedge clk);
            #1;
            if (stb_pcm)
                break;
        end
        pcm_valid = 1'b1;
        pcm_in    = -16'sd32768;
        uc0 = uc;
        @(posedge clk);
        #1;
        pcm_valid = 1'b0;
        check("simul_underrun", int'(underrun), 1, 1);
        check("simul_stored", int'(pcm_ready), 0, 0);
        wait_pcm();
        check("simul_next_no_underrun", int'(underrun), 0, 0);
        pcm_valid = 1'b1;
        wait_pcm();
        check("simul_ramp_ones", period_ones, 52, 57);
        check("simul_underrun_count", uc - uc0, 1, 1);

        // -32768 tone: density 0.25, integrators well inside their range.
        wait_pcm();
        wait_pcm();
        sum_periods(8, total);
        check("tone_neg_ones8", total, 242, 258);

        // Zero tone: 62 or 63 ones in every period.
        pcm_in = '0;
        repeat (4) wait_pcm();
        for (int i = 0; i < 4; i++) begin
            wait_pcm();
            check("tone_zero_ones", period_ones, 62, 63);
        end

        // Disable: back to IDLE at the next stb_pcm, buffer retained.
        enable = 1'b0;
        wait_pcm();
        check("disable_i1_clear", longint'(dut.u_sdm.i1_reg), 0, 0);
        check("disable_buf_kept", int'(pcm_ready), 0, 0);
        check_toggle("disable_toggle", 10);

        // Asynchronous reset in RUN.
        #1;
        enable = 1'b1;
        wait_pcm();
        repeat (37) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_pdm", int'(pdm_out), 0, 0);
        check("arst_ready", int'(pcm_ready), 1, 1);
        check("arst_underrun", int'(underrun), 0, 0);
        check("arst_state_idle", int'(dut.state_reg), 0, 0);
        pcm_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        uc0 = uc;
        wait_pcm();
        wait_pcm();
        check("arst_no_underrun", uc - uc0, 0, 0);
        check_toggle("arst_toggle", 6);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/audio_pdm_tx.md
Name: audio_pdm_tx

Overview:
- PDM transmitter; the playback counterpart of the PDM microphone decimator.
- Accepts 16-bit signed PCM through a valid/ready handshake.
- Linearly interpolates between successive samples at the PDM bit rate.
- Drives a single-bit PDM stream from a second-order sigma-delta modulator.
- Timed by the existing audio clock generator strobes: stb_right/stb_left as bit strobe, stb_pcm as sample strobe.

Parameters:
- OSR, 125: PDM bits per PCM period; must equal stb_sample count per stb_pcm.
- W, 28: modulator integrator width, signed.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- stb_sample  in  1  one-clk PDM bit strobe
- stb_pcm  in  1  one-clk PCM period strobe, coincident with a stb_sample
- enable  in  1  run request
- pcm_in  in  16  signed PCM sample
- pcm_valid  in  1  pcm_in valid
- pcm_ready  out  1  block can accept a sample
- pdm_out  out  1  PDM bit
- underrun  out  1  one-clk pulse: no sample available at stb_pcm

Behaviour:
- Reset (async, rst_n=0):
  - pdm_out=0, underrun=0, pcm_ready=1.
  - Buffer empty; cur=tgt=0; k=0.
  - Integrators = 0; state IDLE.
- Input buffer (one entry):
  - pcm_ready = !buf_full.
  - Transfer when pcm_valid && pcm_ready; sample stored in buf, buf_full=1 next clk.
  - Handshake allowed in any state.
- Handshake and stb_pcm in the same clk:
  - stb_pcm sees the pre-transfer buffer (empty), so that period is an underrun.
  - The sample is still stored.
- On stb_pcm in RUN:
  - If buf_full: cur<=tgt, tgt<=buf, buf_full<=0, k<=0.
  - Else: cur<=tgt (hold tgt), k<=0, underrun pulses 1 clk.
- Interpolator:
  - delta = tgt - cur, 17 bits signed.
  - Per stb_sample, if not stb_pcm: k<=k+1, saturating at OSR-1.
  - Modulator input x = (cur*OSR + k*delta) >>> 1. This is the interpolated value scaled by OSR, halved for loop stability.
  - No divider.
- Modulator (per stb_sample, RUN only):
  - fb = pdm_out ? +FS : -FS, where FS = 32768*OSR.
  - i1 <= sat(i1 + x - fb).
  - i2 <= sat(i2 + i1 - fb).
  - pdm_out <= (next i2 >= 0).
  - sat clamps to ±(2^(W-1)-1).
  - pdm_out changes exactly 1 clk after stb_sample.
- FSM:
  - IDLE:
    - Integrators held 0.
    - pdm_out toggles on each stb_sample (zero-mean silence).
    - Goes to RUN on stb_pcm with enable=1 && buf_full; loads tgt<=buf, cur<=0.
    - stb_pcm with enable=1 and buffer empty: stay IDLE, no underrun pulse.
  - RUN:
    - Goes to IDLE on stb_pcm with enable=0.
    - That stb_pcm clears integrators, cur, tgt, k; the buffer is kept.
    - enable changes between strobes have no effect until the next stb_pcm.
- Latency:
  - A sample accepted in period n becomes tgt at the first stb_pcm after transfer.
  - The interpolated value reaches it OSR bit strobes later.
- Output density: ones density = 0.5 + pcm/131072 in steady state (halved full scale). Full scale maps to 25%..75%.

Decomposition:
- Package audio_pkg:
  - PCM_W=16.
  - OSR_DEFAULT=125.
  - FS_PCM=32768.
  - enum state_t {IDLE, RUN}.
  - Saturation helper function.
- Sub-module audio_sdm2:
  - Ports: clk, rst_n, stb, clr, x[W-1:0], pdm.
  - Contains the two integrators, feedback and saturation.
- The top holds the buffer, interpolator and FSM.

Test Plan:
- Reset mid-operation:
  - Assert rst_n=0 during RUN -> pdm_out=0, pcm_ready=1 immediately (async), state IDLE.
  - No underrun pulse after release.
- Idle silence:
  - enable=0, 20 stb_sample -> pdm_out alternates 0,1,0,1…
  - pcm_ready=1 until one sample is pushed, then 0.
- Steady tones:
  - Feed pcm=0 continuously -> ones count per 125 bits in 62..63.
  - pcm=+16384 -> ones density 0.625 ±1/125 averaged over 8 periods.
  - pcm=-32768 -> 0.25 ±1/125, with no integrator wrap (checked via saturation assert).
- Underrun:
  - Stop pcm_valid for one period -> underrun=1 for exactly one clk at that stb_pcm.
  - Output density holds the last sample's value.
- Simultaneous events:
  - Complete a handshake in the same clk as stb_pcm with an empty buffer -> underrun pulse.
  - The sample is used at the following stb_pcm.
- Ramp interpolation and round trip:
  - Step 0 -> 16384 -> modulator x rises monotonically over 125 bits.
  - With enable deasserted, next stb_pcm -> IDLE toggling resumes.
  - Loop pdm_out into the decimator -> recovered 1 kHz sine within 1% amplitude.
